execute_cycle: RTL and testbench

//  Execute (EX) stage of the 5-stage pipelined 32-bit CPU, between decode and memory.
//  - Selects the ALU B operand and computes the ALU result and the branch target.
//  - Registers results and MEM/WB control bits into the EX/MEM pipeline register.

---
 rtl/execute_cycle_if.sv | 33 +++
 rtl/execute_cycle.sv | 73 +++++++
 tb/tb_execute_cycle.sv | 124 ++++++++++++
 3 files changed

// File: rtl/execute_cycle_if.sv
// execute_cycle_if: decode-to-EX operand/control bundle and EX/MEM register outputs (Zero_out present when EXEC_ZERO_FLAG_EN is defined)
interface execute_cycle_if;
   logic [31:0] PC, ExImm, Op1, Op2, SA;
   logic [4:0]  Rd1;
   logic [1:0]  ALUSrc;
   logic [3:0]  ALUOp;
   logic        mem_R, mem_W, WB, RegW;
   logic [1:0]  PC_Src;
   logic [31:0] branchAddress, Alu_Res;
   logic [4:0]  Rd2;
   logic        mem_R_out, mem_W_out, WB_out, RegW_out;
   logic [1:0]  PC_Src_out;
`ifdef EXEC_ZERO_FLAG_EN
   logic        Zero_out;
   modport master (
      output PC, ExImm, Op1, Op2, SA, Rd1, ALUSrc, ALUOp, mem_R, mem_W, WB, RegW, PC_Src,
      input  branchAddress, Alu_Res, Rd2, mem_R_out, mem_W_out, WB_out, RegW_out, PC_Src_out, Zero_out
   );
   modport slave (
      input  PC, ExImm, Op1, Op2, SA, Rd1, ALUSrc, ALUOp, mem_R, mem_W, WB, RegW, PC_Src,
      output branchAddress, Alu_Res, Rd2, mem_R_out, mem_W_out, WB_out, RegW_out, PC_Src_out, Zero_out
   );
`else
   modport master (
      output PC, ExImm, Op1, Op2, SA, Rd1, ALUSrc, ALUOp, mem_R, mem_W, WB, RegW, PC_Src,
      input  branchAddress, Alu_Res, Rd2, mem_R_out, mem_W_out, WB_out, RegW_out, PC_Src_out
   );
   modport slave (
      input  PC, ExImm, Op1, Op2, SA, Rd1, ALUSrc, ALUOp, mem_R, mem_W, WB, RegW, PC_Src,
      output branchAddress, Alu_Res, Rd2, mem_R_out, mem_W_out, WB_out, RegW_out, PC_Src_out
   );
`endif
endinterface

// File: rtl/execute_cycle.sv
// execute_cycle: EX stage - B-operand select, ALU, branch target, EX/MEM register (optional registered zero flag under EXEC_ZERO_FLAG_EN)
module execute_cycle (
   input logic           clk,
   input logic           rst,
   execute_cycle_if.slave ex
);
   logic [31:0] b_op, alu_d, br_d;
   logic [31:0] alu_res_q, br_q;
   logic [4:0]  rd_q;
   logic        mem_r_q, mem_w_q, wb_q, regw_q;
   logic [1:0]  pc_src_q;
   logic        sa_unused;
   assign sa_unused = ^ex.SA[31:5];
   // operand B select, ALU and branch target, all combinational ahead of the register
   always_comb begin
      b_op = ex.ALUSrc == 2'b01 ? ex.ExImm : ex.ALUSrc == 2'b10 ? {27'b0, ex.SA[4:0]} : ex.Op2;
      br_d = ex.PC + (ex.ExImm << 2);
      case (ex.ALUOp)
         4'b0000: alu_d = ex.Op1 & b_op;
         4'b0001: alu_d = ex.Op1 | b_op;
         4'b0010: alu_d = ex.Op1 + b_op;
         4'b0011: alu_d = ex.Op1 - b_op;
         4'b0100: alu_d = ex.Op1 ^ b_op;
         4'b0101: alu_d = ~(ex.Op1 | b_op);
         4'b0110: alu_d = {31'b0, $signed(ex.Op1) < $signed(b_op)};
         4'b0111: alu_d = {31'b0, ex.Op1 < b_op};
         4'b1000: alu_d = ex.Op1 << b_op[4:0];
         4'b1001: alu_d = ex.Op1 >> b_op[4:0];
         4'b1010: alu_d = $unsigned($signed(ex.Op1) >>> b_op[4:0]);
         4'b1011: alu_d = b_op << 16;
         default: alu_d = 32'h0;
      endcase
   end
   // EX/MEM pipeline register, cleared asynchronously while rst is low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_res_q <= '0;
         br_q      <= '0;
         rd_q      <= '0;
         mem_r_q   <= 1'b0;
         mem_w_q   <= 1'b0;
         wb_q      <= 1'b0;
         regw_q    <= 1'b0;
         pc_src_q  <= '0;
      end else begin
         alu_res_q <= alu_d;
         br_q      <= br_d;
         rd_q      <= ex.Rd1;
         mem_r_q   <= ex.mem_R;
         mem_w_q   <= ex.mem_W;
         wb_q      <= ex.WB;
         regw_q    <= ex.RegW;
         pc_src_q  <= ex.PC_Src;
      end
   end
   assign ex.Alu_Res       = alu_res_q;
   assign ex.branchAddress = br_q;
   assign ex.Rd2           = rd_q;
   assign ex.mem_R_out     = mem_r_q;
   assign ex.mem_W_out     = mem_w_q;
   assign ex.WB_out        = wb_q;
   assign ex.RegW_out      = regw_q;
   assign ex.PC_Src_out    = pc_src_q;
`ifdef EXEC_ZERO_FLAG_EN
   logic zero_q;
   // zero flag registered alongside the ALU result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) zero_q <= 1'b0;
      else      zero_q <= alu_d == 32'h0;
   end
   assign ex.Zero_out = zero_q;
`endif
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed checks of execute_cycle (zero flag checked when EXEC_ZERO_FLAG_EN is defined)
module tb_execute_cycle;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   execute_cycle_if ex ();
   execute_cycle u_dut (.clk(clk), .rst(rst), .ex(ex));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ctl();
      return {26'b0, ex.mem_R_out, ex.mem_W_out, ex.WB_out, ex.RegW_out, ex.PC_Src_out};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] pc, imm, a, b, sa, input logic [1:0] src, input logic [3:0] op);
      ex.PC = pc; ex.ExImm = imm; ex.Op1 = a; ex.Op2 = b; ex.SA = sa; ex.ALUSrc = src; ex.ALUOp = op;
   endtask

   task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] exp);
      ex.ALUOp = op;
      step();
      chk(tag, ex.Alu_Res, exp);
   endtask

   initial begin
      rst = 1'b1;
      drive($urandom, $urandom, $urandom, $urandom, $urandom, 2'($urandom), 4'($urandom));
      ex.Rd1 = 5'($urandom); ex.mem_R = 1'b1; ex.mem_W = 1'b1; ex.WB = 1'b1; ex.RegW = 1'b1; ex.PC_Src = 2'b11;
      #1 rst = 1'b0;
      #1;
      chk("rst_alu", ex.Alu_Res, 32'h0);
      chk("rst_br", ex.branchAddress, 32'h0);
      chk("rst_rd", 32'(ex.Rd2), 32'h0);
      chk("rst_ctl", ctl(), 32'h0);
      step();
      chk("rst_hold_alu", ex.Alu_Res, 32'h0);
      chk("rst_hold_ctl", ctl(), 32'h0);
`ifdef EXEC_ZERO_FLAG_EN
      chk("rst_zero", 32'(ex.Zero_out), 32'h0);
`endif
      drive(32'h4, 32'h0, 32'h0, 32'h01111111, 32'h0, 2'b00, 4'b0010);
      ex.Rd1 = 5'd5; ex.mem_R = 1'b1; ex.mem_W = 1'b0; ex.WB = 1'b1; ex.RegW = 1'b1; ex.PC_Src = 2'b10;
      rst = 1'b1;
      step();
      chk("add_alu", ex.Alu_Res, 32'h01111111);
      chk("add_br", ex.branchAddress, 32'h4);
      chk("add_rd", 32'(ex.Rd2), 32'd5);
      chk("add_ctl", ctl(), 32'b101110);
`ifdef EXEC_ZERO_FLAG_EN
      chk("add_zero", 32'(ex.Zero_out), 32'h0);
`endif
      drive(32'h8, 32'h01111111, 32'hFFFF0000, 32'h0, 32'h0, 2'b01, 4'b0100);
      ex.Rd1 = 5'd31; ex.mem_R = 1'b0; ex.mem_W = 1'b1; ex.WB = 1'b0; ex.RegW = 1'b0; ex.PC_Src = 2'b01;
      step();
      chk("xori_alu", ex.Alu_Res, 32'hFEEE1111);
      chk("xori_br", ex.branchAddress, 32'h0444444C);
      chk("xori_rd", 32'(ex.Rd2), 32'd31);
      chk("xori_ctl", ctl(), 32'b010001);
      drive(32'h100, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h0, 2'b00, 4'b0011);
      step();
      chk("sub_wrap", ex.Alu_Res, 32'hFFFFFFFF);
      chk("br_neg", ex.branchAddress, 32'h000000FC);
      ex.Op1 = 32'hFFFFFFFF;
      alu("slt", 4'b0110, 32'h1);
      alu("sltu", 4'b0111, 32'h0);
      alu("add_wrap", 4'b0010, 32'h0);
      drive(32'h0, 32'h0, 32'h80000001, 32'h0, 32'h24, 2'b10, 4'b1000);
      step();
      chk("sll", ex.Alu_Res, 32'h00000010);
      alu("srl", 4'b1001, 32'h08000000);
      alu("sra", 4'b1010, 32'hF8000000);
      ex.SA = 32'h20;
      alu("sll0", 4'b1000, 32'h80000001);
      alu("sra0", 4'b1010, 32'h80000001);
      drive(32'h0, 32'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1F, 2'b11, 4'b0000);
      step();
      chk("and_src3", ex.Alu_Res, 32'hF000F000);
      alu("or", 4'b0001, 32'hFFF0FFF0);
      alu("nor", 4'b0101, 32'h000F000F);
      alu("op_c", 4'b1100, 32'h0);
      alu("op_f", 4'b1111, 32'h0);
      ex.ALUSrc = 2'b01; ex.ExImm = 32'h00001234;
      alu("lui", 4'b1011, 32'h12340000);
      drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 4'b0010);
      step();
      chk("add_zero_res", ex.Alu_Res, 32'h0);
`ifdef EXEC_ZERO_FLAG_EN
      chk("zero_set", 32'(ex.Zero_out), 32'h1);
`endif
      drive(32'h1000, 32'h4, 32'h12345678, 32'h1, 32'h0, 2'b00, 4'b0010);
      ex.Rd1 = 5'd9; ex.mem_R = 1'b1; ex.mem_W = 1'b1; ex.WB = 1'b1; ex.RegW = 1'b1; ex.PC_Src = 2'b11;
      step();
      chk("pre_rst_alu", ex.Alu_Res, 32'h12345679);
      chk("pre_rst_br", ex.branchAddress, 32'h1010);
      chk("pre_rst_ctl", ctl(), 32'b111111);
      #2 rst = 1'b0;
      #1;
      chk("async_alu", ex.Alu_Res, 32'h0);
      chk("async_br", ex.branchAddress, 32'h0);
      chk("async_rd", 32'(ex.Rd2), 32'h0);
      chk("async_ctl", ctl(), 32'h0);
      step();
      chk("async_hold", ex.Alu_Res, 32'h0);
      rst = 1'b1;
      step();
      chk("release_alu", ex.Alu_Res, 32'h12345679);
      chk("release_ctl", ctl(), 32'b111111);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
